// File: rtl/mem_pkg.sv
// mem_pkg: shared constants, init image and FSM encoding for the memory responder
package mem_pkg;
  localparam int MEM_WORD_W = 32;
  localparam string INIT_FILE = "memfile.dat";
  localparam int INIT_LEN = 4;
  localparam logic [MEM_WORD_W-1:0] INIT_IMAGE [INIT_LEN] = '{32'h2008_0005, 32'h0, 32'h0, 32'h0};
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_RESP = 2'd2} state_t;
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port RAM with synchronous write, registered read and optional preload
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [MEM_WORD_W-1:0] wdata,
  output logic [MEM_WORD_W-1:0] rdata
);
  logic [MEM_WORD_W-1:0] ram [2**DEPTH_LOG2];
`ifdef MEM_RESPONDER_INIT_EN
  initial for (int i = 0; i < INIT_LEN && i < 2**DEPTH_LOG2; i++) ram[i] = INIT_IMAGE[i];
`endif
  always_ff @(posedge clk) begin
    if (wr) ram[idx] <= wdata;
    if (rd) rdata <= ram[idx];
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory slave with req/ready handshake and wait states.
//   clk       - rising-edge clock
//   reset     - asynchronous active-low reset
//   req       - access request, sampled in IDLE only
//   we        - 1 = write, 0 = read, sampled with req
//   address   - byte address
//   writedata - store data, sampled with req
//   readdata  - load data, held until the next read completes
//   ready     - one-cycle completion pulse
//   err       - completion had a bad address, valid with ready
//   busy      - high whenever not IDLE
// Optional preload: define MEM_RESPONDER_INIT_EN (see mem_array).
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [31:0]           address,
    input  logic [MEM_WORD_W-1:0] writedata,
    output logic [MEM_WORD_W-1:0] readdata,
    output logic                  ready,
    output logic                  err,
    output logic                  busy
);
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $fatal(1, "mem_responder: LATENCY must be in 1..15");
    end

    state_t                state, state_nx;
    logic [3:0]            cnt;
    logic [31:0]           addr_q;
    logic                  we_q;
    logic [MEM_WORD_W-1:0] wd_q;
    logic                  err_q;
    logic                  rd_ok;
    logic                  accept, done, bad;
    logic [MEM_WORD_W-1:0] ram_q;

    assign bad = (addr_q[1:0] != 2'b00) || ((addr_q >> (DEPTH_LOG2 + 2)) != '0);

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        done     = 1'b0;
        case (state)
            ST_IDLE: if (req) begin
                accept   = 1'b1;
                state_nx = ST_BUSY;
            end
            ST_BUSY: if (cnt == 4'd1) begin
                done     = 1'b1;
                state_nx = ST_RESP;
            end
            default: state_nx = ST_IDLE;
        endcase
        busy  = state != ST_IDLE;
        ready = state == ST_RESP;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            addr_q <= '0;
            we_q   <= 1'b0;
            wd_q   <= '0;
            err_q  <= 1'b0;
            rd_ok  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_q <= address;
                we_q   <= we;
                wd_q   <= writedata;
                cnt    <= 4'(LATENCY);
            end else if (state == ST_BUSY) begin
                cnt <= cnt - 4'd1;
            end
            if (done) begin
                err_q <= bad;
                if (bad) rd_ok <= 1'b0;
                else if (!we_q) rd_ok <= 1'b1;
            end
        end
    end

    mem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
        .clk   (clk),
        .wr    (done && we_q && !bad),
        .rd    (done && !we_q && !bad),
        .idx   (addr_q[DEPTH_LOG2+1:2]),
        .wdata (wd_q),
        .rdata (ram_q)
    );

    // The RAM output register has no reset; rd_ok masks it to zero after
    // reset and after an erroring completion until a good read reloads it.
    assign readdata = rd_ok ? ram_q : '0;
    assign err      = ready && err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and randomized checks of mem_responder against a word-array model.
module tb_mem_responder;
    localparam int LAT = 2;
    localparam int DL2 = 8;
    localparam int WORDS = 1 << DL2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        ready, err, busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [WORDS];
    bit          known [WORDS];
    logic [31:0] rd_m = '0;

    mem_responder #(.DEPTH_LOG2(DL2), .LATENCY(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .address   (address),
        .writedata (writedata),
        .readdata  (readdata),
        .ready     (ready),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 4 * WORDS);
    endfunction

    // Model of one completed access; returns the expected err flag.
    function automatic bit model(input logic w, input logic [31:0] a, input logic [31:0] d);
        int i = int'(a / 4);
        if (addr_bad(a)) begin
            rd_m = '0;
            return 1'b1;
        end
        if (w) begin
            mem_m[i] = d;
            known[i] = 1'b1;
        end else begin
            rd_m = mem_m[i];
        end
        return 1'b0;
    endfunction

    // Called at posedge+1 with the DUT idle; returns at posedge+1 idle again.
    task automatic access(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        bit e;
        req = 1'b1;
        we = w;
        address = a;
        writedata = d;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ready && n < 20);
        req = 1'b0;
        chk({tag, " latency"}, 32'(n), 32'(LAT + 1));
        e = model(w, a, d);
        chk({tag, " readdata"}, readdata, rd_m);
        chk({tag, " err"}, {31'b0, err}, {31'b0, e});
        chk({tag, " busy"}, {31'b0, busy}, 32'd1);
        @(posedge clk);
        #1;
        chk({tag, " ready_drop"}, {31'b0, ready}, 32'd0);
        chk({tag, " idle"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int prev;
        int pulses;
        int i;
        logic [31:0] a;
        logic        w;

        repeat (2) @(posedge clk);
        #1;
        chk("rst readdata", readdata, 32'd0);
        chk("rst ready", {31'b0, ready}, 32'd0);
        chk("rst err", {31'b0, err}, 32'd0);
        chk("rst busy", {31'b0, busy}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        access("wr0", 1'b1, 32'h0, 32'h1234_5678);
        access("rd0", 1'b0, 32'h0, 32'h0);
        chk("rd0 value", readdata, 32'h1234_5678);

        access("wr3f8", 1'b1, 32'h3F8, 32'h0BAD_F00D);
        access("wr3fc", 1'b1, 32'h3FC, 32'hDEAD_BEEF);
        access("wr_hold", 1'b1, 32'h8, 32'h5555_AAAA);
        chk("write keeps readdata", readdata, 32'h1234_5678);
        access("rd3fc", 1'b0, 32'h3FC, 32'h0);
        chk("rd3fc value", readdata, 32'hDEAD_BEEF);
        access("rd3f8", 1'b0, 32'h3F8, 32'h0);

        access("rd_misaligned", 1'b0, 32'h2, 32'h0);
        access("wr_oob", 1'b1, 32'h400, 32'hFFFF_FFFF);
        access("rd0_after_err", 1'b0, 32'h0, 32'h0);
        chk("rd0 intact", readdata, 32'h1234_5678);

        // Held req, alternating reads: ready must pulse every LAT+2 cycles.
        access("wr10", 1'b1, 32'h10, 32'hA0A0_1010);
        access("wr14", 1'b1, 32'h14, 32'hB0B0_1414);
        req = 1'b1;
        we = 1'b0;
        address = 32'h10;
        prev = -1;
        pulses = 0;
        for (int c = 0; c < 60 && pulses < 5; c++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                void'(model(1'b0, address, 32'h0));
                chk("b2b readdata", readdata, rd_m);
                if (prev >= 0) chk("b2b period", 32'(c - prev), 32'(LAT + 2));
                prev = c;
                pulses++;
                address = (address == 32'h10) ? 32'h14 : 32'h10;
            end
        end
        req = 1'b0;
        chk("b2b pulses", 32'(pulses), 32'd5);
        repeat (2) @(posedge clk);
        #1;
        chk("b2b idle", {31'b0, busy}, 32'd0);

        for (int n = 0; n < 40; n++) begin
            i = $urandom_range(0, 9);
            w = 1'($urandom_range(0, 1));
            if (i == 0) a = (32'($urandom_range(0, WORDS - 1)) << 2) | 32'($urandom_range(1, 3));
            else if (i == 1) a = ($urandom | 32'h0000_0400) & 32'hFFFF_FFFC;
            else a = 32'($urandom_range(0, WORDS - 1)) << 2;
            if (!addr_bad(a) && !known[a / 4]) w = 1'b1;
            access("rand", w, a, $urandom);
        end

        // Abort a write by resetting before its completion edge.
        access("wr20_old", 1'b1, 32'h20, 32'h1111_2222);
        access("rd_before_abort", 1'b0, 32'h8, 32'h0);
        req = 1'b1;
        we = 1'b1;
        address = 32'h20;
        writedata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        rd_m = '0;
        chk("abort busy", {31'b0, busy}, 32'd0);
        chk("abort ready", {31'b0, ready}, 32'd0);
        chk("abort readdata", readdata, 32'd0);
        chk("abort err", {31'b0, err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        access("rd20_after_abort", 1'b0, 32'h20, 32'h0);
        chk("rd20 old value", readdata, 32'h1111_2222);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
